// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and helpers for the whack-a-mole round logic.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    SETTLE = 3'd2,
    SHOW   = 3'd3,
    HIT    = 3'd4,
    MISS   = 3'd5,
    GAP    = 3'd6,
    OVER   = 3'd7
  } state_t;

  localparam int         NUM_MOLES = 5;
  localparam logic [2:0] NO_MOLE   = 3'b111;

  function automatic logic [4:0] onehot5(input logic [2:0] idx);
    onehot5 = (idx < 3'(NUM_MOLES)) ? (5'b00001 << idx) : 5'b00000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mole_picker.sv
`default_nettype none
// ============================================================================
// Module      : mole_picker
// Description : Free-running 8-bit LFSR folded to 0..4 with no back-to-back repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_picker
  import game_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] prev_mole,
  output logic [2:0] next_mole
);

  logic [7:0] r_lfsr;
  logic       w_feedback;
  logic [2:0] w_fold;

  // Fibonacci form, taps 8,6,5,4
  assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_feedback};
    end
  end

  always_comb begin
    w_fold = r_lfsr[2:0];
    if (w_fold >= 3'(NUM_MOLES)) begin
      w_fold = w_fold - 3'(NUM_MOLES);
    end
    next_mole = w_fold;
    if (w_fold == prev_mole) begin
      next_mole = (w_fold == 3'(NUM_MOLES - 1)) ? 3'd0 : w_fold + 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mole_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : mole_round_controller
// Description : Round sequencer: picks moles, scores hits/misses, tracks lives.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_round_controller
  import game_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter int         TIMEOUT_STEP   = 2_000_000,
  parameter int         TIMEOUT_MIN    = 10_000_000,
  parameter int         GAP_CYCLES     = 25_000_000,
  parameter int         LIVES          = 3,
  parameter int         SCORE_W        = 8,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4:0]         buttons,
  input  logic               pulse,
  output logic [2:0]         selector,
  output logic [4:0]         mole_leds,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               hit_strobe,
  output logic               miss_strobe,
  output logic               game_over
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TW-1:0] c_window_init = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] c_step        = TW'(TIMEOUT_STEP);
  localparam logic [TW-1:0] c_min         = TW'(TIMEOUT_MIN);
  localparam logic [GW-1:0] c_gap_last    = GW'(GAP_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_selector;
  logic [4:0]         r_leds;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_lives;
  logic [TW-1:0]      r_window;
  logic [TW-1:0]      r_timer;
  logic [2:0]         r_prev;
  logic [GW-1:0]      r_gap;
  logic [2:0]         w_pick;
  logic               w_wrong;
  logic               w_idle_btn;
  logic               w_above_floor;

  mole_picker #(
    .LFSR_SEED (LFSR_SEED)
  ) u_picker (
    .clk       (clk),
    .rst       (rst),
    .prev_mole (r_prev),
    .next_mole (w_pick)
  );

  assign w_wrong       = |(buttons & ~onehot5(r_selector));
  assign w_idle_btn    = (buttons == 5'b00000);
  // extra bit keeps the floor comparison free of overflow
  assign w_above_floor = ({1'b0, r_window} >= ({1'b0, c_min} + {1'b0, c_step}));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, OVER: if (start) w_next = ARM;
      ARM:        if (w_idle_btn) w_next = SETTLE;
      SETTLE:     w_next = SHOW;
      SHOW: begin
        if (w_wrong)                 w_next = MISS;
        else if (pulse)              w_next = HIT;
        else if (r_timer == TW'(1))  w_next = MISS;
      end
      HIT:        w_next = GAP;
      MISS:       w_next = (r_lives <= 3'd1) ? OVER : GAP;
      GAP:        if (r_gap == c_gap_last) w_next = ARM;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_selector <= NO_MOLE;
      r_leds     <= 5'b00000;
      r_score    <= '0;
      r_lives    <= 3'(LIVES);
      r_window   <= c_window_init;
      r_timer    <= '0;
      r_prev     <= NO_MOLE;
      r_gap      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE, OVER: begin
          if (start) begin
            r_score  <= '0;
            r_lives  <= 3'(LIVES);
            r_window <= c_window_init;
          end
        end
        ARM: begin
          // mole is chosen on the cycle the buttons are seen released
          if (w_idle_btn) begin
            r_selector <= w_pick;
            r_leds     <= onehot5(w_pick);
            r_prev     <= w_pick;
            r_timer    <= r_window;
          end
        end
        SHOW: begin
          r_timer <= r_timer - TW'(1);
          if (w_next != SHOW) begin
            r_selector <= NO_MOLE;
            r_leds     <= 5'b00000;
          end
        end
        HIT: begin
          if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + SCORE_W'(1);
          r_window <= w_above_floor ? (r_window - c_step) : c_min;
          r_gap    <= '0;
        end
        MISS: begin
          r_lives <= r_lives - 3'd1;
          r_gap   <= '0;
        end
        GAP: r_gap <= r_gap + GW'(1);
        default: ;
      endcase
    end
  end

  assign selector    = r_selector;
  assign mole_leds   = r_leds;
  assign score       = r_score;
  assign lives       = r_lives;
  assign hit_strobe  = (r_state == HIT);
  assign miss_strobe = (r_state == MISS);
  assign game_over   = (r_state == OVER);

endmodule
`default_nettype wire

// File: tb/tb_mole_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mole_round_controller
// Description : Directed table, hand sequences and random rounds vs. a round-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_round_controller;

  localparam int TO = 20, STEP = 4, TMIN = 12, GAPC = 4, NL = 3;
  localparam int K_HIT = 0, K_WRONG = 1, K_BOTH = 2, K_TIMEOUT = 3;

  logic       clk = 1'b0;
  logic       rst, start, pulse;
  logic [4:0] buttons;
  logic [2:0] selector, lives;
  logic [4:0] mole_leds;
  logic [7:0] score;
  logic       hit_strobe, miss_strobe, game_over;

  mole_round_controller #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_STEP   (STEP),
    .TIMEOUT_MIN    (TMIN),
    .GAP_CYCLES     (GAPC),
    .LIVES          (NL),
    .SCORE_W        (8),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .buttons     (buttons),
    .pulse       (pulse),
    .selector    (selector),
    .mole_leds   (mole_leds),
    .score       (score),
    .lives       (lives),
    .hit_strobe  (hit_strobe),
    .miss_strobe (miss_strobe),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // one-cycle registered validation MUX
  always @(posedge clk or posedge rst) begin
    if (rst) pulse <= 1'b0;
    else     pulse <= (selector < 3'd5) ? buttons[selector] : 1'b0;
  end

  typedef struct {
    int kind;
    int k;
    int exp_cyc;
    int exp_score;
    int exp_lives;
    int exp_over;
  } vec_t;

  vec_t tbl[9];
  int   n_vec = 0;
  int   n_bad = 0;
  int   prev_sel = 7;

  function automatic logic [4:0] oh(input int i);
    logic [4:0] one;
    one = 5'b00001;
    oh  = (i >= 0 && i < 5) ? (one << i) : 5'd0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_score", int'(score), 0);
    check("start_lives", int'(lives), NL);
    check("start_over", int'(game_over), 0);
  endtask

  task automatic play_round(input int kind, input int k, input int exp_cyc,
                            input int exp_score, input int exp_lives, input int exp_over,
                            output int waited);
    int sel, n, other;
    bit found;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      waited++;
      if (selector != 3'b111) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      check("mole_appears", 0, 1);
      return;
    end
    sel = int'(selector);
    check("sel_range", int'(sel < 5), 1);
    check("sel_no_repeat", int'(sel != prev_sel), 1);
    check("leds_onehot", int'(mole_leds), int'(oh(sel)));
    prev_sel = sel;
    step();  // first SHOW cycle
    case (kind)
      K_HIT: begin
        repeat (k) step();
        buttons = oh(sel);
        step();
        buttons = 5'd0;
        check("hit_early", int'(hit_strobe), 0);
        step();
        check("hit_strobe", int'(hit_strobe), 1);
        check("hit_no_miss", int'(miss_strobe), 0);
      end
      K_WRONG, K_BOTH: begin
        repeat (k) step();
        other   = (sel + 1 + int'($urandom_range(0, 3))) % 5;
        buttons = oh(other) | ((kind == K_BOTH) ? oh(sel) : 5'd0);
        step();
        buttons = 5'd0;
        check("wrong_miss", int'(miss_strobe), 1);
        check("wrong_no_hit", int'(hit_strobe), 0);
      end
      default: begin
        n = 0;
        for (int i = 0; i < 200; i++) begin
          step();
          n++;
          if (miss_strobe || hit_strobe) break;
        end
        check("timeout_cycles", n, exp_cyc);
        check("timeout_miss", int'(miss_strobe), 1);
      end
    endcase
    step();
    check("round_score", int'(score), exp_score);
    check("round_lives", int'(lives), exp_lives);
    check("round_over", int'(game_over), exp_over);
    check("round_sel_blank", int'(selector), 7);
  endtask

  initial begin
    int  waited, ms, ml, mw, kind, k, cyc, r;
    bit  mover, ok;

    tbl[0] = '{K_HIT,     5,  0, 1, 3, 0};
    tbl[1] = '{K_HIT,     0,  0, 2, 3, 0};
    tbl[2] = '{K_HIT,     9,  0, 3, 3, 0};
    tbl[3] = '{K_TIMEOUT, 0, 12, 3, 2, 0};
    tbl[4] = '{K_WRONG,   2,  0, 3, 1, 0};
    tbl[5] = '{K_BOTH,    3,  0, 3, 0, 1};
    tbl[6] = '{K_TIMEOUT, 0, 20, 0, 2, 0};
    tbl[7] = '{K_TIMEOUT, 0, 20, 0, 1, 0};
    tbl[8] = '{K_TIMEOUT, 0, 20, 0, 0, 1};

    rst = 1'b1; start = 1'b0; buttons = 5'd0;
    step();
    step();
    check("rst_selector", int'(selector), 7);
    check("rst_leds", int'(mole_leds), 0);
    check("rst_score", int'(score), 0);
    check("rst_lives", int'(lives), NL);
    check("rst_strobes", int'({hit_strobe, miss_strobe}), 0);
    check("rst_over", int'(game_over), 0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      if (i == 0 || i == 6) do_start();
      play_round(tbl[i].kind, tbl[i].k, tbl[i].exp_cyc, tbl[i].exp_score,
                 tbl[i].exp_lives, tbl[i].exp_over, waited);
    end
    check("over_sel_blank", int'(selector), 7);

    // held button stalls ARM; release goes straight to SETTLE
    do_start();
    buttons = 5'b00100;
    ok = 1'b1;
    repeat (12) begin
      step();
      if (selector != 3'b111 || miss_strobe) ok = 1'b0;
    end
    check("arm_hold_stall", int'(ok), 1);
    buttons = 5'd0;
    play_round(K_HIT, 3, 0, 1, 3, 0, waited);
    check("arm_release_latency", waited, 1);

    // asynchronous reset in the middle of SHOW
    for (int i = 0; i < 50; i++) begin
      step();
      if (selector != 3'b111) break;
    end
    step();
    step();
    #3 rst = 1'b1;
    #1;
    check("arst_selector", int'(selector), 7);
    check("arst_leds", int'(mole_leds), 0);
    check("arst_score", int'(score), 0);
    check("arst_lives", int'(lives), NL);
    check("arst_strobes", int'({hit_strobe, miss_strobe, game_over}), 0);
    step();
    rst = 1'b0;
    prev_sel = 7;
    repeat (3) step();
    check("idle_sel_blank", int'(selector), 7);

    // random rounds against the round-level model
    mover = 1'b1;
    ms = 0; ml = NL; mw = TO;
    for (int rnd = 0; rnd < 200; rnd++) begin
      if (mover) begin
        do_start();
        ms = 0; ml = NL; mw = TO; mover = 1'b0;
      end
      r = int'($urandom_range(0, 5));
      kind = (r <= 2) ? K_HIT : (r == 3) ? K_WRONG : (r == 4) ? K_BOTH : K_TIMEOUT;
      k    = (kind == K_HIT) ? int'($urandom_range(0, mw - 2)) : int'($urandom_range(0, mw - 1));
      cyc  = mw;
      if (kind == K_HIT) begin
        ms = (ms < 255) ? ms + 1 : ms;
        mw = (mw - STEP >= TMIN) ? mw - STEP : TMIN;
      end else begin
        ml--;
        mover = (ml == 0);
      end
      play_round(kind, k, cyc, ms, ml, int'(mover), waited);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
